// File: rtl/ir_key_fifo.sv
// Purpose : validate decoded NEC frames and buffer accepted keys in a show-ahead FIFO.
// Latency : 2 cycles from the first Get_Flag-high cycle to the entry/err/ovf result.
// Backpress: none upstream; a valid frame arriving at a full FIFO with no pop is dropped and counted.
//
// Ports:
//   Clk, Rst_n          clock, synchronous active-low reset
//   irAddr, irData      decoded NEC address / data (data[7:0] command, data[15:8] complement)
//   Get_Flag            decode-complete level; only its rising edge starts a frame
//   rd_en               pop head entry (ignored when empty)
//   key_cmd, key_addr   head entry (show-ahead, forced to 0 while empty)
//   empty, full, level  FIFO occupancy
//   key_err, ovf        one-cycle pulses: frame rejected / valid frame dropped
//   err_cnt, ovf_cnt    saturating counters of the above
module ir_key_fifo #(
  parameter int          DEPTH_LOG2     = 2,
  parameter bit          STRICT_ADDR    = 1'b1,
  parameter bit          ADDR_FILTER_EN = 1'b0,
  parameter logic [15:0] ADDR_FILTER    = 16'hFF00
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [15:0]           irAddr,
  input  logic [15:0]           irData,
  input  logic                  Get_Flag,
  input  logic                  rd_en,
  output logic [7:0]            key_cmd,
  output logic [15:0]           key_addr,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  key_err,
  output logic                  ovf,
  output logic [7:0]            err_cnt,
  output logic [7:0]            ovf_cnt
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Frame event: rising edge of Get_Flag. flag_d resets high so that a flag
  // already asserted when reset releases does not produce a frame.
  // ---------------------------------------------------------------------------
  logic flag_d;
  logic frame_evt;

  assign frame_evt = Get_Flag & ~flag_d;

  // Frame validation on the live decoder outputs, captured with the frame.
  logic cmd_ok;
  logic addr_ok;
  logic filt_ok;

  assign cmd_ok  = (irData[15:8] == ~irData[7:0]);
  assign addr_ok = !STRICT_ADDR || (irAddr[15:8] == ~irAddr[7:0]);
  assign filt_ok = !ADDR_FILTER_EN || (irAddr == ADDR_FILTER);

  // ---------------------------------------------------------------------------
  // Capture stage S1: single register, no stall. A new event simply
  // overwrites it; events are at least two cycles apart since each needs a
  // low-to-high transition, so nothing is lost.
  // ---------------------------------------------------------------------------
  logic        s1_vld;
  logic        s1_ok;
  logic [15:0] s1_addr;
  logic [7:0]  s1_cmd;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      flag_d  <= 1'b1;
      s1_vld  <= 1'b0;
      s1_ok   <= 1'b0;
      s1_addr <= '0;
      s1_cmd  <= '0;
    end else begin
      flag_d <= Get_Flag;
      s1_vld <= frame_evt;
      if (frame_evt) begin
        s1_ok   <= cmd_ok & addr_ok & filt_ok;
        s1_addr <= irAddr;
        s1_cmd  <= irData[7:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit stage. A pop in the same cycle frees a slot in a full FIFO, so the
  // write is still allowed; a pop on an empty FIFO is ignored.
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_fire;
  logic                  wr_allow;
  logic                  wr_fire;
  logic                  drop_fire;
  logic                  rej_fire;

  assign rd_fire   = rd_en & ~empty;
  assign wr_allow  = ~full | rd_fire;
  assign wr_fire   = Rst_n & s1_vld & s1_ok & wr_allow;
  assign drop_fire = s1_vld & s1_ok & ~wr_allow;
  assign rej_fire  = s1_vld & ~s1_ok;

  // Storage: {addr, cmd}. Contents are not reset; head outputs are gated by
  // empty so stale data is never presented.
  logic [23:0] mem [DEPTH];
  logic [23:0] head;

  always_ff @(posedge Clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= {s1_addr, s1_cmd};
    end
  end

  assign head     = mem[rd_ptr];
  assign key_cmd  = empty ? 8'h00  : head[7:0];
  assign key_addr = empty ? 16'h0000 : head[23:8];

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

  // Pointers, level, pulses and counters.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      key_err <= 1'b0;
      ovf     <= 1'b0;
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      // Simultaneous push and pop leaves the level unchanged.
      case ({wr_fire, rd_fire})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase

      key_err <= rej_fire;
      ovf     <= drop_fire;

      if (rej_fire && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (drop_fire && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_key_fifo.sv
// Purpose : directed self-checking bench for ir_key_fifo.
// Two instances share stimulus: the default build (strict address, no filter)
// and an extended-address build that only accepts address 16'h1234.
module tb_ir_key_fifo;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] irAddr;
  logic [15:0] irData;
  logic        Get_Flag;
  logic        rd_en;

  logic [7:0]  key_cmd;
  logic [15:0] key_addr;
  logic        empty, full;
  logic [2:0]  level;
  logic        key_err, ovf;
  logic [7:0]  err_cnt, ovf_cnt;

  logic [7:0]  x_key_cmd;
  logic [15:0] x_key_addr;
  logic        x_empty, x_full;
  logic [2:0]  x_level;
  logic        x_key_err, x_ovf;
  logic [7:0]  x_err_cnt, x_ovf_cnt;

  int nchk = 0;
  int nerr = 0;

  always #10 Clk = ~Clk;

  ir_key_fifo #(.DEPTH_LOG2(2), .STRICT_ADDR(1'b1), .ADDR_FILTER_EN(1'b0), .ADDR_FILTER(16'hFF00)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .irAddr(irAddr), .irData(irData), .Get_Flag(Get_Flag),
    .rd_en(rd_en), .key_cmd(key_cmd), .key_addr(key_addr), .empty(empty), .full(full),
    .level(level), .key_err(key_err), .ovf(ovf), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt)
  );

  ir_key_fifo #(.DEPTH_LOG2(2), .STRICT_ADDR(1'b0), .ADDR_FILTER_EN(1'b1), .ADDR_FILTER(16'h1234)) dut_x (
    .Clk(Clk), .Rst_n(Rst_n), .irAddr(irAddr), .irData(irData), .Get_Flag(Get_Flag),
    .rd_en(rd_en), .key_cmd(x_key_cmd), .key_addr(x_key_addr), .empty(x_empty), .full(x_full),
    .level(x_level), .key_err(x_key_err), .ovf(x_ovf), .err_cnt(x_err_cnt), .ovf_cnt(x_ovf_cnt)
  );

  // Advance one clock; outputs are then stable for sampling and inputs may change.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One frame: flag high for one cycle (edge E captures), then low and the
  // bus scrambled so the commit must use the captured copy (edge E+1 commits).
  task automatic frame(input logic [15:0] a, input logic [15:0] d);
    irAddr   = a;
    irData   = d;
    Get_Flag = 1'b1;
    step();
    Get_Flag = 1'b0;
    irAddr   = 16'hDEAD;
    irData   = 16'h0000;
    step();
  endtask

  function automatic logic [15:0] nec(input logic [7:0] c);
    return {~c, c};
  endfunction

  task automatic pop_chk(input string tag, input logic [7:0] exp_cmd);
    chk(tag, {24'h0, key_cmd}, {24'h0, exp_cmd});
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; Get_Flag = 1'b0; rd_en = 1'b0; irAddr = '0; irData = '0;
    step(); step();
    Rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_empty",   {31'h0, empty},    32'h1);
    chk("rst_full",    {31'h0, full},     32'h0);
    chk("rst_level",   {29'h0, level},    32'h0);
    chk("rst_cmd",     {24'h0, key_cmd},  32'h0);
    chk("rst_addr",    {16'h0, key_addr}, 32'h0);
    chk("rst_err_cnt", {24'h0, err_cnt},  32'h0);
    chk("rst_ovf_cnt", {24'h0, ovf_cnt},  32'h0);
    chk("rst_pulses",  {30'h0, key_err, ovf}, 32'h0);

    // Single valid frame, with the two-cycle latency checked at edge E
    irAddr = 16'hFF00; irData = 16'hBA45; Get_Flag = 1'b1;
    step();
    chk("lat_empty_at_E", {31'h0, empty}, 32'h1);
    Get_Flag = 1'b0; irAddr = 16'hDEAD; irData = 16'h0000;
    step();
    chk("single_empty", {31'h0, empty},    32'h0);
    chk("single_cmd",   {24'h0, key_cmd},  32'h45);
    chk("single_addr",  {16'h0, key_addr}, 32'hFF00);
    chk("single_level", {29'h0, level},    32'h1);
    chk("single_noerr", {31'h0, key_err},  32'h0);
    chk("filt_reject",  {31'h0, x_key_err}, 32'h1);
    chk("filt_empty",   {31'h0, x_empty},   32'h1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("single_pop_empty", {31'h0, empty}, 32'h1);
    chk("single_pop_level", {29'h0, level}, 32'h0);

    // Bad command complement
    frame(16'hFF00, 16'hBA44);
    chk("bad_key_err", {31'h0, key_err}, 32'h1);
    chk("bad_err_cnt", {24'h0, err_cnt}, 32'h1);
    chk("bad_empty",   {31'h0, empty},   32'h1);
    step();
    chk("bad_pulse_one", {31'h0, key_err}, 32'h0);
    chk("bad_cnt_hold",  {24'h0, err_cnt}, 32'h1);

    // Extended address: rejected by strict build, accepted by extended build
    frame(16'h1234, 16'hF708);
    chk("ext_strict_err",  {31'h0, key_err},    32'h1);
    chk("ext_strict_cnt",  {24'h0, err_cnt},    32'h2);
    chk("ext_strict_emp",  {31'h0, empty},      32'h1);
    chk("ext_x_empty",     {31'h0, x_empty},    32'h0);
    chk("ext_x_cmd",       {24'h0, x_key_cmd},  32'h08);
    chk("ext_x_addr",      {16'h0, x_key_addr}, 32'h1234);
    chk("ext_x_level",     {29'h0, x_level},    32'h1);
    chk("ext_x_noerr",     {31'h0, x_key_err},  32'h0);

    // Overflow: four fit, fifth is dropped
    frame(16'hFF00, nec(8'h01));
    frame(16'hFF00, nec(8'h02));
    frame(16'hFF00, nec(8'h03));
    chk("ovf_lvl3_full", {31'h0, full}, 32'h0);
    frame(16'hFF00, nec(8'h04));
    chk("ovf_full",   {31'h0, full},  32'h1);
    chk("ovf_level4", {29'h0, level}, 32'h4);
    frame(16'hFF00, nec(8'h05));
    chk("ovf_pulse",  {31'h0, ovf},     32'h1);
    chk("ovf_cnt1",   {24'h0, ovf_cnt}, 32'h1);
    chk("ovf_keep",   {29'h0, level},   32'h4);
    step();
    chk("ovf_pulse_one", {31'h0, ovf}, 32'h0);
    pop_chk("ovf_pop1", 8'h01);
    pop_chk("ovf_pop2", 8'h02);
    pop_chk("ovf_pop3", 8'h03);
    pop_chk("ovf_pop4", 8'h04);
    chk("ovf_drained", {31'h0, empty}, 32'h1);

    // Pop on empty is ignored
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("rd_empty_level", {29'h0, level}, 32'h0);
    chk("rd_empty_empty", {31'h0, empty}, 32'h1);

    // Full FIFO with pop in the commit cycle of the fifth frame
    frame(16'hFF00, nec(8'h01));
    frame(16'hFF00, nec(8'h02));
    frame(16'hFF00, nec(8'h03));
    frame(16'hFF00, nec(8'h04));
    irAddr = 16'hFF00; irData = nec(8'h05); Get_Flag = 1'b1;
    step();
    Get_Flag = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fullrw_no_ovf", {31'h0, ovf},     32'h0);
    chk("fullrw_level",  {29'h0, level},   32'h4);
    chk("fullrw_ovfcnt", {24'h0, ovf_cnt}, 32'h1);
    pop_chk("fullrw_pop2", 8'h02);
    pop_chk("fullrw_pop3", 8'h03);
    pop_chk("fullrw_pop4", 8'h04);
    pop_chk("fullrw_pop5", 8'h05);
    chk("fullrw_drained", {31'h0, empty}, 32'h1);

    // Pop together with write on an empty FIFO: write wins
    irAddr = 16'hFF00; irData = nec(8'h77); Get_Flag = 1'b1;
    step();
    Get_Flag = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("emptyrw_level", {29'h0, level},   32'h1);
    chk("emptyrw_cmd",   {24'h0, key_cmd}, 32'h77);
    pop_chk("emptyrw_pop", 8'h77);

    // Back-to-back frames
    frame(16'hFF00, nec(8'hA1));
    frame(16'hFF00, nec(8'hB2));
    chk("b2b_level", {29'h0, level}, 32'h2);
    pop_chk("b2b_pop1", 8'hA1);
    pop_chk("b2b_pop2", 8'hB2);

    // Held flag: one entry only
    irAddr = 16'hFF00; irData = nec(8'h11); Get_Flag = 1'b1;
    for (int i = 0; i < 100; i++) step();
    chk("held_level", {29'h0, level},   32'h1);
    chk("held_cmd",   {24'h0, key_cmd}, 32'h11);
    Get_Flag = 1'b0;
    pop_chk("held_pop", 8'h11);
    chk("held_empty", {31'h0, empty}, 32'h1);

    // Error counter saturation: 2 so far + 260 more rejects
    for (int i = 0; i < 260; i++) frame(16'hFF00, 16'h0000);
    chk("err_sat", {24'h0, err_cnt}, 32'hFF);

    // Flag already high when reset releases
    Rst_n = 1'b0; Get_Flag = 1'b1; irAddr = 16'hFF00; irData = nec(8'h22);
    step();
    Rst_n = 1'b1;
    step(); step(); step();
    chk("flag_at_rst_level", {29'h0, level},   32'h0);
    chk("flag_at_rst_empty", {31'h0, empty},   32'h1);
    chk("rst_clr_err",       {24'h0, err_cnt}, 32'h0);
    chk("rst_clr_ovf",       {24'h0, ovf_cnt}, 32'h0);
    Get_Flag = 1'b0;
    step();

    // Reset mid-pipeline with 3 entries stored and a bad frame in flight
    frame(16'hFF00, nec(8'h31));
    frame(16'hFF00, nec(8'h32));
    frame(16'hFF00, nec(8'h33));
    frame(16'hFF00, 16'h1111);
    chk("mid_pre_level", {29'h0, level},   32'h3);
    chk("mid_pre_err",   {24'h0, err_cnt}, 32'h1);
    irAddr = 16'hFF00; irData = 16'h2222; Get_Flag = 1'b1;
    step();
    Get_Flag = 1'b0; Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    chk("mid_level",   {29'h0, level},   32'h0);
    chk("mid_empty",   {31'h0, empty},   32'h1);
    chk("mid_err_cnt", {24'h0, err_cnt}, 32'h0);
    chk("mid_key_err", {31'h0, key_err}, 32'h0);
    step();
    chk("mid_no_pulse", {31'h0, key_err}, 32'h0);
    chk("mid_err_hold", {24'h0, err_cnt}, 32'h0);
    chk("mid_empty2",   {31'h0, empty},   32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
